// File: rtl/ysyx_23060201_lsu_if.sv
// Bundle of the LSU's three handshake channels: upstream operation, downstream
// result, and the memory request/response bus.
//   slave  : the LSU's view (takes operations, drives results and memory requests)
//   master : the surrounding pipeline/memory view
interface ysyx_23060201_lsu_if;
  // Upstream operation channel
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [2:0]  in_funct3;
  logic        in_load;
  logic        in_store;
  // Result channel to writeback
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  // Memory bus
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  modport slave (
    input  in_valid, in_addr, in_wdata, in_funct3, in_load, in_store,
    output in_ready,
    output out_valid, out_data, out_err,
    input  out_ready,
    output mem_req_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport master (
    output in_valid, in_addr, in_wdata, in_funct3, in_load, in_store,
    input  in_ready,
    input  out_valid, out_data, out_err,
    output out_ready,
    input  mem_req_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: accepts one operation at a time, validates it, issues a
// single word-aligned memory request for legal accesses, extracts/extends load
// data and presents the result to writeback.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - slave side of ysyx_23060201_lsu_if (operation, result, memory bus)
module ysyx_23060201_lsu (
  input logic                clk,
  input logic                rst_n,
  ysyx_23060201_lsu_if.slave bus
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic in_ready_q, in_ready_n;
  logic out_valid_q, out_valid_n;
  logic mem_req_valid_q, mem_req_valid_n;

  logic [XLEN-1:0] out_data_q;
  logic            out_err_q;
  logic [XLEN-1:0] mem_addr_q;
  logic            mem_wen_q;
  logic [3:0]      mem_wstrb_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic [1:0]      off_q;
  logic [2:0]      funct3_q;
  logic            load_q;

  logic            accept_c;
  logic            is_mem_c;
  logic            legal_load_c;
  logic            legal_store_c;
  logic            misalign_c;
  logic            access_err_c;
  logic [3:0]      strb_c;
  logic [XLEN-1:0] wdata_c;
  logic [7:0]      byte_c;
  logic [15:0]     half_c;
  logic [XLEN-1:0] load_data_c;

  assign accept_c = (state == S_IDLE) && bus.in_valid;
  assign is_mem_c = bus.in_load || bus.in_store;

  // Operation legality and alignment of the offered operation
  always_comb begin
    legal_load_c  = 1'b0;
    legal_store_c = 1'b0;
    misalign_c    = 1'b0;
    case (bus.in_funct3)
      3'b000, 3'b001, 3'b010: begin
        legal_load_c  = 1'b1;
        legal_store_c = 1'b1;
      end
      3'b100, 3'b101: legal_load_c = 1'b1;
      default: ;
    endcase
    case (bus.in_funct3[1:0])
      SZ_HALF: misalign_c = bus.in_addr[0];
      2'b10:   misalign_c = (bus.in_addr[1:0] != 2'b00);
      default: misalign_c = 1'b0;
    endcase
    access_err_c = (bus.in_load && bus.in_store)
                || (bus.in_load && !legal_load_c)
                || (bus.in_store && !legal_store_c)
                || (is_mem_c && misalign_c);
  end

  // Store lane replication and byte strobes
  always_comb begin
    strb_c  = 4'b1111;
    wdata_c = bus.in_wdata;
    case (bus.in_funct3[1:0])
      SZ_BYTE: begin
        strb_c  = 4'(4'b0001 << bus.in_addr[1:0]);
        wdata_c = {4{bus.in_wdata[7:0]}};
      end
      SZ_HALF: begin
        strb_c  = bus.in_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{bus.in_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection and extension of the returned read word
  always_comb begin
    byte_c = bus.mem_rdata[7:0];
    case (off_q)
      2'd1:    byte_c = bus.mem_rdata[15:8];
      2'd2:    byte_c = bus.mem_rdata[23:16];
      2'd3:    byte_c = bus.mem_rdata[31:24];
      default: byte_c = bus.mem_rdata[7:0];
    endcase
    half_c = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data_c = {{24{byte_c[7]}}, byte_c};
      3'b100:  load_data_c = {24'd0, byte_c};
      3'b001:  load_data_c = {{16{half_c[15]}}, half_c};
      3'b101:  load_data_c = {16'd0, half_c};
      default: load_data_c = bus.mem_rdata;
    endcase
  end

  // State register; handshake outputs are registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      in_ready_q      <= 1'b1;
      out_valid_q     <= 1'b0;
      mem_req_valid_q <= 1'b0;
    end else begin
      state           <= state_next;
      in_ready_q      <= in_ready_n;
      out_valid_q     <= out_valid_n;
      mem_req_valid_q <= mem_req_valid_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_next = (access_err_c || !is_mem_c) ? S_DONE : S_REQ;
        end
      end
      S_REQ:  if (bus.mem_req_ready) state_next = S_WAIT;
      S_WAIT: if (bus.mem_rsp_valid) state_next = S_DONE;
      S_DONE: if (bus.out_ready)     state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode of the state being entered
  always_comb begin
    in_ready_n      = 1'b0;
    out_valid_n     = 1'b0;
    mem_req_valid_n = 1'b0;
    case (state_next)
      S_IDLE:  in_ready_n      = 1'b1;
      S_REQ:   mem_req_valid_n = 1'b1;
      S_DONE:  out_valid_n     = 1'b1;
      default: ;
    endcase
  end

  // Operation capture, request fields and result data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= '0;
      off_q       <= 2'b00;
      funct3_q    <= 3'b000;
      load_q      <= 1'b0;
    end else begin
      if (accept_c) begin
        off_q    <= bus.in_addr[1:0];
        funct3_q <= bus.in_funct3;
        load_q   <= bus.in_load;
        if (access_err_c) begin
          out_data_q <= '0;
          out_err_q  <= 1'b1;
        end else if (!is_mem_c) begin
          out_data_q <= bus.in_addr;
          out_err_q  <= 1'b0;
        end else begin
          // Stores finish with zero data; loads overwrite on the response
          out_data_q  <= '0;
          out_err_q   <= 1'b0;
          mem_addr_q  <= {bus.in_addr[31:2], 2'b00};
          mem_wen_q   <= bus.in_store;
          mem_wstrb_q <= bus.in_store ? strb_c : 4'b0000;
          mem_wdata_q <= bus.in_store ? wdata_c : '0;
        end
      end
      if ((state == S_WAIT) && bus.mem_rsp_valid && load_q) begin
        out_data_q <= load_data_c;
      end
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_err       = out_err_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wen       = mem_wen_q;
  assign bus.mem_wstrb     = mem_wstrb_q;
  assign bus.mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Bench for ysyx_23060201_lsu: a transaction-level model of the expected
// visible behaviour, checked every cycle, plus directed literal scenarios and
// a randomized phase with backpressure, spurious responses and resets.
module tb_ysyx_23060201_lsu;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_23060201_lsu_if bus();

  ysyx_23060201_lsu dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model of the operation in flight
  logic        in_rst = 1'b1;
  logic        m_busy = 1'b0;
  logic        m_mem = 1'b0;
  logic        m_req_done = 1'b0;
  logic        m_rsp_done = 1'b0;
  logic        m_load = 1'b0;
  logic [2:0]  m_f3 = 3'b000;
  logic [1:0]  m_off = 2'b00;
  logic [31:0] m_addr_exp = '0;
  logic [31:0] m_wdata_exp = '0;
  logic [31:0] m_data_exp = '0;
  logic [3:0]  m_strb_exp = '0;
  logic        m_wen_exp = 1'b0;
  logic        m_err_exp = 1'b0;

  int obs_req_hs = 0;
  int obs_out_hs = 0;
  int model_done = 0;

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Value a load returns from a memory word
  function automatic logic [31:0] load_value(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] off);
    int bits;
    logic [31:0] mask, v;
    bits = 8 << int'(f3[1:0]);
    mask = (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
    v = (word >> (8 * int'(off))) & mask;
    if (!f3[2] && bits < 32 && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic model_accept(input logic [31:0] a, input logic [31:0] wd,
                              input logic [2:0] f3, input logic ld, input logic st);
    int size;
    logic legal, err;
    if (ld && st)  legal = 1'b0;
    else if (ld)   legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
    else if (st)   legal = (f3 < 3'd3);
    else           legal = 1'b1;
    size = 1 << int'(f3[1:0]);
    err  = (ld || st) && (!legal || ((int'(a[1:0]) % size) != 0));
    m_busy      = 1'b1;
    m_req_done  = 1'b0;
    m_rsp_done  = 1'b0;
    m_load      = ld;
    m_f3        = f3;
    m_off       = a[1:0];
    m_mem       = (ld || st) && !err;
    m_err_exp   = err;
    m_data_exp  = (err || ld || st) ? 32'd0 : a;
    m_addr_exp  = a & 32'hFFFF_FFFC;
    m_wen_exp   = st && !err;
    m_strb_exp  = m_wen_exp ? 4'(((1 << size) - 1) << a[1:0]) : 4'b0000;
    case (size)
      1:       m_wdata_exp = 32'(wd[7:0]) * 32'h0101_0101;
      2:       m_wdata_exp = 32'(wd[15:0]) * 32'h0001_0001;
      default: m_wdata_exp = wd;
    endcase
  endtask

  task automatic model_clear();
    m_busy     = 1'b0;
    m_mem      = 1'b0;
    m_req_done = 1'b0;
    m_rsp_done = 1'b0;
  endtask

  // One clock: drive inputs, advance, then update the model with the handshakes
  task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] iw,
                      input logic [2:0] f3, input logic ld, input logic st,
                      input logic rq, input logic rv, input logic [31:0] rd,
                      input logic orr);
    logic acc, req_hs, rsp_hs, out_hs;
    bus.in_valid      = iv;
    bus.in_addr       = ia;
    bus.in_wdata      = iw;
    bus.in_funct3     = f3;
    bus.in_load       = ld;
    bus.in_store      = st;
    bus.mem_req_ready = rq;
    bus.mem_rsp_valid = rv;
    bus.mem_rdata     = rd;
    bus.out_ready     = orr;
    acc    = iv && !m_busy && rst_n;
    req_hs = m_busy && m_mem && !m_req_done && rq;
    rsp_hs = m_busy && m_mem && m_req_done && !m_rsp_done && rv;
    out_hs = m_busy && (!m_mem || m_rsp_done) && orr;
    if (bus.mem_req_valid && rq) obs_req_hs++;
    if (bus.out_valid && orr)    obs_out_hs++;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_clear();
    end else begin
      if (out_hs) begin
        m_busy = 1'b0;
        model_done++;
      end
      if (rsp_hs) begin
        m_rsp_done = 1'b1;
        if (m_load) m_data_exp = load_value(rd, m_f3, m_off);
      end
      if (req_hs) m_req_done = 1'b1;
      if (acc) model_accept(ia, iw, f3, ld, st);
    end
  endtask

  task automatic idle(input logic rq, input logic rv, input logic [31:0] rd, input logic orr);
    step(1'b0, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0, rq, rv, rd, orr);
  endtask

  // Offered while busy: must have no effect
  task automatic junk(input logic rq, input logic rv, input logic orr);
    step(1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), rq, rv, $urandom, orr);
  endtask

  task automatic do_reset(input int n);
    rst_n  = 1'b0;
    in_rst = 1'b1;
    model_clear();
    repeat (n) idle(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b0);
    rst_n  = 1'b1;
    in_rst = 1'b0;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!in_rst) begin
      chk1("in_ready", bus.in_ready, !m_busy);
      chk1("mem_req_valid", bus.mem_req_valid, m_busy && m_mem && !m_req_done);
      if (bus.mem_req_valid && m_busy && m_mem) begin
        chk32("mem_addr", bus.mem_addr, m_addr_exp);
        chk1("mem_wen", bus.mem_wen, m_wen_exp);
        chk32("mem_wstrb", 32'(bus.mem_wstrb), 32'(m_strb_exp));
        if (m_wen_exp) chk32("mem_wdata", bus.mem_wdata, m_wdata_exp);
      end
      chk1("out_valid", bus.out_valid, m_busy && (!m_mem || m_rsp_done));
      if (bus.out_valid && m_busy) begin
        chk32("out_data", bus.out_data, m_data_exp);
        chk1("out_err", bus.out_err, m_err_exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic        iv, ld, st, rq, rv, orr;
    logic [2:0]  f3;
    logic [31:0] ia;
    int          k, base_req, base_out, base_done;

    // Model pins
    chk32("model_lb", load_value(32'h80FF_7F01, 3'b000, 2'd3), 32'hFFFF_FF80);
    chk32("model_lhu", load_value(32'h80FF_7F01, 3'b101, 2'd2), 32'h0000_80FF);

    // Reset state
    rst_n = 1'b0;
    repeat (3) idle(1'b0, 1'b0, 32'd0, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b1);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_out_err", bus.out_err, 1'b0);
    chk1("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
    chk1("rst_mem_wen", bus.mem_wen, 1'b0);
    chk32("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk32("rst_out_data", bus.out_data, 32'd0);
    chk32("rst_mem_addr", bus.mem_addr, 32'd0);
    rst_n  = 1'b1;
    in_rst = 1'b0;
    idle(1'b0, 1'b0, 32'd0, 1'b0);

    // Pass-through
    step(1'b1, 32'h0000_1234, 32'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk1("pt_out_valid", bus.out_valid, 1'b1);
    chk32("pt_out_data", bus.out_data, 32'h0000_1234);
    chk1("pt_no_req", bus.mem_req_valid, 1'b0);
    idle(1'b0, 1'b0, 32'd0, 1'b1);

    // LB then LBU at byte 3
    for (int u = 0; u < 2; u++) begin
      step(1'b1, 32'h8000_0003, 32'd0, (u == 0) ? 3'b000 : 3'b100, 1'b1, 1'b0,
           1'b0, 1'b0, 32'd0, 1'b0);
      chk1("lb_req_valid", bus.mem_req_valid, 1'b1);
      chk32("lb_mem_addr", bus.mem_addr, 32'h8000_0000);
      chk1("lb_mem_wen", bus.mem_wen, 1'b0);
      idle(1'b1, 1'b0, 32'd0, 1'b0);
      idle(1'b0, 1'b1, 32'h80FF_7F01, 1'b0);
      chk1("lb_out_valid", bus.out_valid, 1'b1);
      chk32("lb_out_data", bus.out_data, (u == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      idle(1'b0, 1'b0, 32'd0, 1'b1);
    end

    // SH upper half
    step(1'b1, 32'h8000_0002, 32'h1234_ABCD, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk32("sh_wstrb", 32'(bus.mem_wstrb), 32'h0000_000C);
    chk32("sh_wdata", bus.mem_wdata, 32'hABCD_ABCD);
    chk1("sh_wen", bus.mem_wen, 1'b1);
    idle(1'b1, 1'b0, 32'd0, 1'b0);
    idle(1'b0, 1'b1, 32'd0, 1'b0);
    chk32("sh_out_data", bus.out_data, 32'd0);
    idle(1'b0, 1'b0, 32'd0, 1'b1);

    // Misaligned LW
    base_req = obs_req_hs;
    step(1'b1, 32'h8000_0001, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk1("mis_out_valid", bus.out_valid, 1'b1);
    chk1("mis_out_err", bus.out_err, 1'b1);
    chk1("mis_no_req", bus.mem_req_valid, 1'b0);
    idle(1'b1, 1'b0, 32'd0, 1'b1);
    chk32("mis_req_count", 32'(obs_req_hs - base_req), 32'd0);

    // Backpressure on request then on result
    base_req = obs_req_hs;
    base_out = obs_out_hs;
    step(1'b1, 32'h8000_0010, 32'hCAFE_F00D, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    repeat (5) begin
      junk(1'b0, 1'b1, 1'b1);
      chk32("bp_mem_addr", bus.mem_addr, 32'h8000_0010);
      chk32("bp_mem_wdata", bus.mem_wdata, 32'hCAFE_F00D);
    end
    idle(1'b1, 1'b0, 32'd0, 1'b0);
    idle(1'b0, 1'b1, 32'd0, 1'b0);
    repeat (3) begin
      junk(1'b1, 1'b1, 1'b0);
      chk1("bp_out_valid", bus.out_valid, 1'b1);
      chk32("bp_out_data", bus.out_data, 32'd0);
    end
    idle(1'b0, 1'b0, 32'd0, 1'b1);
    chk32("bp_req_count", 32'(obs_req_hs - base_req), 32'd1);
    chk32("bp_out_count", 32'(obs_out_hs - base_out), 32'd1);

    // Reset while waiting for the response, then a late response
    step(1'b1, 32'h0000_0020, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    idle(1'b1, 1'b0, 32'd0, 1'b0);
    do_reset(1);
    idle(1'b0, 1'b1, 32'h1111_2222, 1'b1);
    chk1("rw_in_ready", bus.in_ready, 1'b1);
    chk1("rw_out_valid", bus.out_valid, 1'b0);
    idle(1'b0, 1'b0, 32'd0, 1'b1);
    chk1("rw_out_valid2", bus.out_valid, 1'b0);

    // Randomized traffic
    base_out  = obs_out_hs;
    base_done = model_done;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1);
      end else begin
        iv = m_busy ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) < 7);
        k  = int'($urandom_range(0, 19));
        ld = (k < 8) || (k >= 18);
        st = ((k >= 8) && (k < 15)) || (k >= 18);
        if ($urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 4))
            0: f3 = 3'b000;
            1: f3 = 3'b001;
            2: f3 = 3'b010;
            3: f3 = 3'b100;
            default: f3 = 3'b101;
          endcase
        end else begin
          f3 = 3'($urandom_range(0, 7));
        end
        ia = $urandom;
        if ($urandom_range(0, 1) == 1) ia[1:0] = 2'b00;
        rq  = ($urandom_range(0, 2) != 0);
        if (m_busy && m_mem && m_req_done && !m_rsp_done) rv = ($urandom_range(0, 4) < 3);
        else rv = ($urandom_range(0, 6) == 0);
        orr = ($urandom_range(0, 4) < 3);
        step(iv, ia, $urandom, f3, ld, st, rq, rv, $urandom, orr);
      end
    end
    for (int d = 0; d < 20 && m_busy; d++) idle(1'b1, m_req_done, $urandom, 1'b1);
    chk32("rand_transfers", 32'(obs_out_hs - base_out), 32'(model_done - base_done));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
